// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- RV32I instruction fetch stage
//
// Owns the PC and fetches one instruction at a time from instruction memory.
// It keeps at most one request outstanding. The fetched word is held in the
// IF/ID register that feeds the decoder. That register supports stall,
// redirect/flush and a one-word skid buffer.
//
// Parameters
//   RESET_PC  PC of the first fetch after reset
//   NOP_INST  word presented on inst_id while the IF/ID slot is empty
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_req_valid   fetch request valid (only while in FETCH)
//   imem_req_ready   memory accepts the request this cycle
//   imem_addr        word-aligned fetch address
//   imem_rsp_valid   response valid, one per accepted request
//   imem_rsp_data    fetched instruction word
//   stall            decoder cannot accept; IF/ID holds its contents
//   redirect_valid   taken branch/jump; flushes fetch
//   redirect_pc      new PC (bits [1:0] ignored)
//   inst_id          instruction to the decoder
//   pc_id            PC of inst_id
//   inst_valid       inst_id holds a real instruction
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | just out of reset, first request goes out next cycle
// FETCH | request asserted at req_addr, waiting for the handshake
// WAIT  | request accepted, waiting for the response
// HOLD  | response parked in the skid register while IF/ID is stalled full
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst_id,
   output logic [31:0] pc_id,
   output logic        inst_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] req_addr;
   logic [31:0] req_addr_nxt;
   logic        drop;
   logic        drop_nxt;
   logic [31:0] skid_data;
   logic [31:0] skid_data_nxt;
   logic [31:0] inst_nxt;
   logic [31:0] pc_id_nxt;
   logic        valid_nxt;

   logic        handshake;
   logic        slot_free;
   logic [31:0] seq_addr;
   logic [31:0] redir_addr;

   assign imem_req_valid = (state == FETCH);
   assign imem_addr      = req_addr;

   assign handshake  = (state == FETCH) && imem_req_ready;
   assign slot_free  = !inst_valid || !stall;
   assign seq_addr   = req_addr + 32'd4;
   assign redir_addr = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_ADDR;
         req_addr   <= RESET_ADDR;
         drop       <= 1'b0;
         skid_data  <= NOP_INST;
         inst_id    <= NOP_INST;
         pc_id      <= 32'd0;
         inst_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         req_addr   <= req_addr_nxt;
         drop       <= drop_nxt;
         skid_data  <= skid_data_nxt;
         inst_id    <= inst_nxt;
         pc_id      <= pc_id_nxt;
         inst_valid <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      req_addr_nxt  = req_addr;
      drop_nxt      = drop;
      skid_data_nxt = skid_data;
      inst_nxt      = inst_id;
      pc_id_nxt     = pc_id;
      valid_nxt     = inst_valid;

      // The decoder takes the current word whenever it is not stalled. A load
      // further down in this block overrides this in the same cycle.
      if (!stall) begin
         valid_nxt = 1'b0;
         inst_nxt  = NOP_INST;
      end

      case (state)
         IDLE: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            if (handshake) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (drop) begin
                  // Stale response from before a redirect. pc already holds
                  // the redirect target.
                  drop_nxt     = 1'b0;
                  req_addr_nxt = pc;
                  state_nxt    = FETCH;
               end else if (slot_free) begin
                  inst_nxt     = imem_rsp_data;
                  pc_id_nxt    = req_addr;
                  valid_nxt    = 1'b1;
                  pc_nxt       = seq_addr;
                  req_addr_nxt = seq_addr;
                  state_nxt    = FETCH;
               end else begin
                  skid_data_nxt = imem_rsp_data;
                  state_nxt     = HOLD;
               end
            end
         end
         HOLD: begin
            // req_addr still names the parked word; it advances only when the
            // word moves into IF/ID.
            if (!stall) begin
               inst_nxt     = skid_data;
               pc_id_nxt    = req_addr;
               valid_nxt    = 1'b1;
               pc_nxt       = seq_addr;
               req_addr_nxt = seq_addr;
               state_nxt    = FETCH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A redirect wins over stall and over any load computed above.
      if (redirect_valid) begin
         valid_nxt = 1'b0;
         inst_nxt  = NOP_INST;
         pc_id_nxt = pc_id;
         pc_nxt    = redir_addr;
         case (state)
            IDLE: begin
               req_addr_nxt = redir_addr;
               state_nxt    = FETCH;
            end
            FETCH: begin
               // An asserted request must keep its address until accepted.
               // Its response is thrown away later.
               drop_nxt     = 1'b1;
               req_addr_nxt = req_addr;
               state_nxt    = handshake ? WAIT : FETCH;
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  drop_nxt     = 1'b0;
                  req_addr_nxt = redir_addr;
                  state_nxt    = FETCH;
               end else begin
                  drop_nxt     = 1'b1;
                  req_addr_nxt = req_addr;
                  state_nxt    = WAIT;
               end
            end
            HOLD: begin
               drop_nxt     = 1'b0;
               req_addr_nxt = redir_addr;
               state_nxt    = FETCH;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the RV32I core; directly upstream of the instruction decoder.
- Owns the PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request channel and a valid-only response channel.
- Holds the fetched word in the IF/ID pipeline register that feeds the decoder's `inst` input, with stall, redirect/flush and skid buffering.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INST, 32'h0000_0013, word presented on inst_id when the slot is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  32  word-aligned fetch address; bits[1:0] are always 0.
- imem_rsp_valid  input  1  response data valid; exactly one response per accepted request, at least 1 cycle after the handshake.
- imem_rsp_data  input  32  fetched instruction word.
- stall  input  1  ID stage cannot accept; IF/ID register holds its contents.
- redirect_valid  input  1  branch/jump taken; flushes fetch.
- redirect_pc  input  32  new PC; bits[1:0] are ignored and forced to 0.
- inst_id  output  32  instruction to the decoder.
- pc_id  output  32  PC of inst_id.
- inst_valid  output  1  inst_id holds a real instruction.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC, drop=0, skid empty.
  - Outputs: imem_req_valid=0, imem_addr=RESET_PC, inst_id=NOP_INST, pc_id=0, inst_valid=0.
- States: IDLE, FETCH, WAIT, HOLD. imem_req_valid=1 only in FETCH. imem_addr=req_addr.
- IDLE:
  - Always goes to FETCH next cycle.
  - The first request is therefore asserted 1 cycle after reset release.
- FETCH:
  - On imem_req_valid & imem_req_ready, go to WAIT.
  - req_addr and imem_addr stay stable from request assertion until the handshake, including across a redirect.
- WAIT:
  - On imem_rsp_valid with drop=1: discard the response, clear drop, set req_addr=pc, go to FETCH.
  - On imem_rsp_valid with drop=0 and the slot free (inst_valid=0 or stall=0):
    - Load inst_id=rsp_data, pc_id=req_addr, inst_valid=1.
    - Set pc=req_addr+4 and req_addr=req_addr+4, go to FETCH.
  - Otherwise (slot occupied and stalled): capture the word into the skid register and go to HOLD.
- HOLD:
  - When stall=0, move the skid word into IF/ID, advance pc by 4 and req_addr to match, go to FETCH.
- Consumption:
  - When stall=0 and no new word loads that cycle, inst_valid goes to 0 and inst_id to NOP_INST.
  - When stall=1, inst_id, pc_id and inst_valid hold.
- Redirect (highest priority, overrides stall and any load in that cycle):
  - IF/ID is flushed: inst_valid=0, inst_id=NOP_INST. pc=redirect_pc.
  - FETCH without handshake: the request keeps its old address; drop=1; it completes and is dropped.
  - FETCH with handshake in the same cycle: go to WAIT with drop=1.
  - WAIT: drop=1. A response arriving in the same cycle is itself discarded; go to FETCH with req_addr=redirect_pc.
  - HOLD: skid discarded; go to FETCH with req_addr=redirect_pc.
  - FETCH/IDLE with drop=0 and no request asserted yet: req_addr=redirect_pc.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Outstanding requests never exceed 1. Throughput is at most one instruction per 2 cycles; this is intentional.
- Reset asserted mid-operation returns to reset values immediately. A response for a request issued before reset is the memory's responsibility and is not expected.

Test Plan:
- Reset release, ready=1, rsp 1 cycle later with 32'h00500093:
  - Request addr 0 on cycle 1 after reset.
  - inst_id=32'h00500093, pc_id=0, inst_valid=1.
  - Next request addr 4.
- Back-to-back sequential fetch of 4 words (ready=1, 1-cycle latency):
  - pc_id sequence 0,4,8,C, each valid once per 2 cycles.
  - imem_addr never misaligned.
- stall=1 held 5 cycles while the next response arrives:
  - inst_id unchanged, new word in skid, no new request.
  - On stall=0, the skid word appears with pc_id+4 and a request resumes.
- redirect_valid with redirect_pc=32'h0000_0103 while in WAIT:
  - inst_valid=0 that cycle; the pending response is discarded.
  - The next request addr is 32'h0000_0100.
- ready=0 for 3 cycles with redirect on cycle 2:
  - imem_addr stays at the old address until the handshake.
  - Its response is dropped; the following request addr is redirect_pc.
- PC=32'hFFFF_FFFC fetch completes -> next imem_addr=0. Assert rst_n=0 mid-WAIT -> all outputs return to reset values asynchronously.
